// File: rtl/sr_mdu_if.sv
// sr_mdu_if -- request/result bundle between the execute-stage controller
// and the iterative multiply unit.
//   mdu_vld_in  : request, held high by the controller through execute
//   mdu_op      : 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4-7 reserved
//   mdu_a/b     : operands (rs1/rs2 data)
//   mdu_clear   : writeback acknowledge; also aborts a running operation
//   mdu_vld_out : result valid (registered)
//   mdu_result  : selected half of the product (registered)
interface sr_mdu_if #(
   parameter int WIDTH = 32
);
   logic             mdu_vld_in;
   logic [2:0]       mdu_op;
   logic [WIDTH-1:0] mdu_a;
   logic [WIDTH-1:0] mdu_b;
   logic             mdu_clear;
   logic             mdu_vld_out;
   logic [WIDTH-1:0] mdu_result;

   modport master (
      output mdu_vld_in, mdu_op, mdu_a, mdu_b, mdu_clear,
      input  mdu_vld_out, mdu_result
   );

   modport slave (
      input  mdu_vld_in, mdu_op, mdu_a, mdu_b, mdu_clear,
      output mdu_vld_out, mdu_result
   );
endinterface

// File: rtl/sr_mdu.sv
// sr_mdu -- radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// One multiplier bit per cycle over the operand magnitudes, sign fixed up
// on the final iteration.
// Ports:
//   clk      : single clock, rising edge
//   reset_n  : asynchronous active-low reset
//   mdu      : sr_mdu_if slave modport (request, operands, clear, result)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request; result register holds last value
// BUSY  | iterating, counter 0..WIDTH-1, one multiplier bit per cycle
// DONE  | result valid and stable until the controller clears it
module sr_mdu #(
   parameter int WIDTH = 32
) (
   input  logic   clk,
   input  logic   reset_n,
   sr_mdu_if.slave mdu
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_q, b_q;
   logic [2:0]         op_q;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               vld_q;

   logic start, step, finish, abort, ack;

   logic               sign_a, sign_b, neg;
   logic [WIDTH-1:0]   mag_a, mag_b, addend;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] prod_fix;

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (mdu.mdu_vld_in && !mdu.mdu_clear) state_d = ST_BUSY;
         ST_BUSY: begin
            if (mdu.mdu_clear)          state_d = ST_IDLE;
            else if (cnt_q == CNT_LAST) state_d = ST_DONE;
         end
         ST_DONE: if (mdu.mdu_clear) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- control strobes ----------------
   always_comb begin
      start  = 1'b0;
      step   = 1'b0;
      finish = 1'b0;
      abort  = 1'b0;
      ack    = 1'b0;
      case (state_q)
         ST_IDLE: start = mdu.mdu_vld_in && !mdu.mdu_clear;
         ST_BUSY: begin
            abort  = mdu.mdu_clear;
            step   = !mdu.mdu_clear;
            finish = !mdu.mdu_clear && (cnt_q == CNT_LAST);
         end
         ST_DONE: ack = mdu.mdu_clear;
         default: ;
      endcase
   end

   // ---------------- datapath ----------------
   // Only the signs that the op actually uses take part in the fixup.
   always_comb begin
      sign_a = a_q[WIDTH-1] && ((op_q == OP_MULH) || (op_q == OP_MULHSU));
      sign_b = b_q[WIDTH-1] && (op_q == OP_MULH);
      neg    = sign_a ^ sign_b;
      // The most negative value negates to itself, which read as unsigned
      // is already the correct magnitude.
      mag_a  = sign_a ? -a_q : a_q;
      mag_b  = sign_b ? -b_q : b_q;
      addend = mag_b[cnt_q] ? mag_a : '0;

      // Right-shifting accumulator: add into the upper half, shift down.
      sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
      acc_d  = {sum, acc_q[WIDTH-1:1]};
      cnt_d  = cnt_q + CW'(1);

      prod_fix = neg ? -acc_d : acc_d;
      case (op_q)
         OP_MUL:                        result_d = prod_fix[WIDTH-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  result_d = prod_fix[2*WIDTH-1:WIDTH];
         default:                       result_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         acc_q    <= '0;
         result_q <= '0;
         vld_q    <= 1'b0;
      end else begin
         if (start) begin
            a_q   <= mdu.mdu_a;
            b_q   <= mdu.mdu_b;
            op_q  <= mdu.mdu_op;
            acc_q <= '0;
            cnt_q <= '0;
         end else if (step) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
         end else if (abort) begin
            cnt_q <= '0;
         end

         if (finish) begin
            result_q <= result_d;
            vld_q    <= 1'b1;
         end else if (ack) begin
            vld_q    <= 1'b0;
         end
      end
   end

   assign mdu.mdu_vld_out = vld_q;
   assign mdu.mdu_result  = result_q;

endmodule

// File: tb/tb_sr_mdu.sv
module tb_sr_mdu;

   localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;

   logic clk;
   logic reset_n;
   int   checks;
   int   errors;

   sr_mdu_if #(.WIDTH(32)) mif ();

   sr_mdu #(.WIDTH(32)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .mdu     (mif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: full-width product of sign/zero-extended operands, then
   // pick the requested half.
   function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] ea, eb, p;
      ea = {32'b0, a};
      eb = {32'b0, b};
      if (op == MULH || op == MULHSU) ea = {{32{a[31]}}, a};
      if (op == MULH)                 eb = {{32{b[31]}}, b};
      p = ea * eb;
      case (op)
         MUL:                  return p[31:0];
         MULH, MULHSU, MULHU:  return p[63:32];
         default:              return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   // Present a request at a negedge; returns just after the start edge with
   // the operands scrambled (they must have been captured already).
   task automatic tsk_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      mif.mdu_clear  = 1'b0;
      mif.mdu_vld_in = 1'b1;
      mif.mdu_op     = op;
      mif.mdu_a      = a;
      mif.mdu_b      = b;
      @(posedge clk);
      #1;
      mif.mdu_op = 3'($urandom_range(0, 7));
      mif.mdu_a  = $urandom;
      mif.mdu_b  = $urandom;
   endtask

   // Cycles 1..32 after the start edge must be low, cycle 33 high.
   task automatic tsk_wait_done(input string tag, input logic [31:0] exp);
      int early;
      early = 0;
      for (int i = 1; i <= 32; i++) begin
         @(negedge clk);
         if (mif.mdu_vld_out !== 1'b0) early++;
      end
      chk({tag, "_vld_low_1_32"}, early, 0);
      @(negedge clk);
      chk({tag, "_vld_33"}, mif.mdu_vld_out, 1'b1);
      chk({tag, "_result"}, mif.mdu_result, exp);
   endtask

   // Acknowledge from DONE; returns 1ns after the edge, in the IDLE cycle.
   task automatic tsk_clear(input string tag, input logic [31:0] held);
      @(negedge clk);
      mif.mdu_clear  = 1'b1;
      mif.mdu_vld_in = 1'b0;
      @(posedge clk);
      #1;
      mif.mdu_clear = 1'b0;
      chk({tag, "_vld_after_clear"}, mif.mdu_vld_out, 1'b0);
      chk({tag, "_result_held"}, mif.mdu_result, held);
   endtask

   task automatic tsk_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
      logic [31:0] exp;
      exp = ref_mdu(op, a, b);
      tsk_start(op, a, b);
      tsk_wait_done(tag, exp);
      tsk_clear(tag, exp);
   endtask

   initial begin
      logic [31:0] last;
      int          bad;
      checks = 0;
      errors = 0;
      reset_n        = 1'b0;
      mif.mdu_vld_in = 1'b0;
      mif.mdu_op     = 3'd0;
      mif.mdu_a      = '0;
      mif.mdu_b      = '0;
      mif.mdu_clear  = 1'b0;

      repeat (3) @(negedge clk);
      chk("reset_vld", mif.mdu_vld_out, 1'b0);
      chk("reset_result", mif.mdu_result, 32'h0);
      reset_n = 1'b1;

      // Directed cases
      tsk_start(MUL, 32'd7, 32'd6);
      tsk_wait_done("mul7x6", 32'd42);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (mif.mdu_vld_out !== 1'b1 || mif.mdu_result !== 32'd42) bad++;
      end
      chk("mul7x6_hold_done", bad, 0);
      tsk_clear("mul7x6", 32'd42);

      tsk_op("mulhu_ff", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      tsk_op("mulh_ff", MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      tsk_op("mulh_8000", MULH, 32'h8000_0000, 32'h8000_0000);
      tsk_op("mulhsu_m2x3", MULHSU, 32'hFFFF_FFFE, 32'd3);
      tsk_op("mul_m2x3", MUL, 32'hFFFF_FFFE, 32'd3);
      tsk_op("mulhsu_8000", MULHSU, 32'h8000_0000, 32'hFFFF_FFFF);
      tsk_op("mul_zero", MUL, 32'h0, 32'hDEAD_BEEF);
      tsk_op("reserved", 3'd5, 32'h1234_5678, 32'h9ABC_DEF0);
      tsk_op("mulhu_pre_abort", MULHU, 32'hFFFF_0000, 32'h0001_0000);
      last = ref_mdu(MULHU, 32'hFFFF_0000, 32'h0001_0000);

      // Abort in BUSY at cycle 10 (request still high), then restart next cycle
      tsk_start(MUL, 32'd5, 32'd5);
      bad = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (mif.mdu_vld_out !== 1'b0) bad++;
      end
      chk("abort_vld_low", bad, 0);
      mif.mdu_clear  = 1'b1;
      mif.mdu_vld_in = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_vld", mif.mdu_vld_out, 1'b0);
      chk("abort_result_kept", mif.mdu_result, last);
      tsk_start(MUL, 32'd3, 32'd4);
      tsk_wait_done("restart3x4", 32'd12);

      // Request held in DONE: no restart; then clear+request in IDLE: no start
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (mif.mdu_vld_out !== 1'b1 || mif.mdu_result !== 32'd12) bad++;
      end
      chk("done_no_restart", bad, 0);
      @(negedge clk);
      mif.mdu_clear  = 1'b1;
      mif.mdu_vld_in = 1'b1;
      @(negedge clk);
      chk("clear_in_done_vld", mif.mdu_vld_out, 1'b0);
      @(negedge clk);
      mif.mdu_clear  = 1'b0;
      mif.mdu_vld_in = 1'b0;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (mif.mdu_vld_out !== 1'b0 || mif.mdu_result !== 32'd12) bad++;
      end
      chk("clear_wins_no_start", bad, 0);

      // Asynchronous reset mid-operation
      tsk_start(MULHU, 32'hFFFF_FFFF, 32'h0000_0010);
      repeat (20) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("async_rst_vld", mif.mdu_vld_out, 1'b0);
      chk("async_rst_result", mif.mdu_result, 32'h0);
      mif.mdu_vld_in = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (mif.mdu_vld_out !== 1'b0 || mif.mdu_result !== 32'h0) bad++;
      end
      chk("no_pulse_after_rst", bad, 0);
      tsk_op("mul2x9", MUL, 32'd2, 32'd9);

      // Randomized ops, each restarted in the first IDLE cycle after clear
      for (int n = 0; n < 40; n++) begin
         logic [2:0]  op;
         logic [31:0] a, b;
         op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
         a  = pick_operand();
         b  = pick_operand();
         tsk_op("rand", op, a, b);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sr_mdu.md
SR_MDU -- requirements
Module: sr_mdu

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width; only 32 is required to be supported.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 mdu_vld_in  input  1  request; the controller holds it high for the whole execute phase.
REQ-005 mdu_op  input  3  operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4-7 reserved.
REQ-006 mdu_a  input  WIDTH  operand A (rs1 data).
REQ-007 mdu_b  input  WIDTH  operand B (rs2 data).
REQ-008 mdu_clear  input  1  the controller acknowledges the result in its writeback cycle; also aborts an operation in progress.
REQ-009 mdu_vld_out  output  1  the result is valid; registered.
REQ-010 mdu_result  output  WIDTH  the selected 32 bits of the product; registered.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-012 IDLE SHALL move to BUSY when mdu_vld_in=1 and mdu_clear=0.
  - On that edge the block captures mdu_a, mdu_b and mdu_op.
  - The iteration counter is cleared to 0.
REQ-013 Operand and op changes after capture SHALL be ignored until the next start.
REQ-014 In BUSY the block SHALL run a radix-2 shift-add multiply over the operand magnitudes, one bit per cycle, for exactly 32 cycles (counter 0..31).
REQ-015 Signedness SHALL be handled as follows:
  - MULH: both operands are signed.
  - MULHSU: A is signed, B is unsigned.
  - MULHU and MUL: both operands are unsigned.
  - A negative operand is replaced by its two's-complement magnitude.
  - The 64-bit product is negated when exactly one used sign is negative.
REQ-016 On the edge where the counter equals 31, the block SHALL write the sign-corrected result to mdu_result and enter DONE.
  - MUL writes product[31:0].
  - MULH, MULHSU and MULHU write product[63:32].
  - Reserved ops write 0.
REQ-017 Latency: if start is sampled at the end of cycle 0, mdu_vld_out SHALL be 1 from cycle 33 onward.
REQ-018 In DONE, mdu_vld_out=1 and mdu_result SHALL hold stable; mdu_vld_in=1 in DONE SHALL NOT start a new operation.
REQ-019 mdu_clear=1 in DONE SHALL return the FSM to IDLE on that edge; mdu_vld_out SHALL be 0 in the next cycle.
REQ-020 mdu_clear=1 in BUSY SHALL abort the operation:
  - The FSM returns to IDLE.
  - The counter clears.
  - mdu_result keeps its previous value.
  - mdu_vld_out stays 0.
REQ-021 mdu_clear=1 together with mdu_vld_in=1 in IDLE SHALL NOT start an operation; clear wins.
REQ-022 mdu_result SHALL change only on completion (REQ-016) or reset; it holds its value in IDLE after clear.
REQ-023 A new start SHALL be accepted in the cycle immediately after a return to IDLE.
REQ-024 Operand edge cases SHALL need no special casing:
  - A zero operand gives 0.
  - 0x80000000 as a signed operand uses magnitude 0x80000000 in 33-bit or unsigned arithmetic.

Reset
REQ-025 While reset_n=0, the block SHALL hold: state IDLE, counter 0, mdu_vld_out 0, mdu_result 0, captured operands 0.
REQ-026 Assertion of reset_n=0 mid-operation SHALL take effect immediately and asynchronously, with no completion pulse afterwards.
REQ-027 After reset_n deasserts, the first start SHALL be accepted on the first rising edge where mdu_vld_in=1.

Verification
REQ-028 MUL, A=7, B=6, vld_in held high from cycle 0 -> vld_out=0 in cycles 1-32; vld_out=1 and result=42 at cycle 33; result held until clear; vld_out=0 the cycle after clear.
REQ-029 MULHU, A=B=0xFFFFFFFF -> result=0xFFFFFFFE. MULH, A=B=0xFFFFFFFF -> result=0x00000000. MULH, A=0x80000000, B=0x80000000 -> result=0x40000000.
REQ-030 MULHSU, A=0xFFFFFFFE (-2), B=3 -> result=0xFFFFFFFF. MUL, same operands -> result=0xFFFFFFFA.
REQ-031 Start MUL 5*5, clear at cycle 10 -> vld_out never rises and result keeps its old value; restart with 3*4 the next cycle -> result=12, 33 cycles after the restart.
REQ-032 Hold vld_in=1 for 5 cycles into DONE with no clear -> a single completion, no restart, result stable. Then clear and vld_in=1 in the same IDLE cycle -> no start.
REQ-033 Assert reset_n=0 at cycle 20 of an operation -> vld_out=0 and result=0 immediately; after release, MUL 2*9 -> result=18.
